// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised RGB-LCD sync/DE timing with one-cycle-ahead pixel request; colour bars with LCD_TEST_PATTERN_EN
module lcd_timing_gen #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_DISP   = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_DISP   = 480,
  parameter int V_FRONT  = 10,
  parameter bit SYNC_POL = 1'b0,
  parameter int COORD_W  = 11,
  parameter int RGB_W    = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               test_mode,
  input  logic [RGB_W-1:0]   pixel_data,
  output logic               data_req,
  output logic [COORD_W-1:0] pixel_xpos,
  output logic [COORD_W-1:0] pixel_ypos,
  output logic               lcd_hs,
  output logic               lcd_vs,
  output logic               lcd_de,
  output logic [RGB_W-1:0]   lcd_rgb,
  output logic               lcd_bl,
  output logic               frame_start
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_S    = COORD_W'(H_SYNC);
  localparam logic [COORD_W-1:0] V_S    = COORD_W'(V_SYNC);
  localparam logic [COORD_W-1:0] H_A0   = COORD_W'(H_SYNC + H_BACK);
  localparam logic [COORD_W-1:0] H_A1   = COORD_W'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [COORD_W-1:0] V_A0   = COORD_W'(V_SYNC + V_BACK);
  localparam logic [COORD_W-1:0] V_A1   = COORD_W'(V_SYNC + V_BACK + V_DISP - 1);
  localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic               h_wrap, v_wrap;
  logic [RGB_W-1:0]   colour;
  assign h_wrap     = h_cnt == H_LAST;
  assign v_wrap     = v_cnt == V_LAST;
  assign data_req   = h_cnt >= H_A0 && h_cnt <= H_A1 && v_cnt >= V_A0 && v_cnt <= V_A1;
  assign pixel_xpos = data_req ? h_cnt - H_A0 : '0;
  assign pixel_ypos = data_req ? v_cnt - V_A0 : '0;
`ifdef LCD_TEST_PATTERN_EN
  localparam int XW = COORD_W + 3;
  localparam int CW = RGB_W / 3;
  logic [2:0] bar;
  // bar = xpos*8/H_DISP by counting crossed bar boundaries
  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++)
      if ({pixel_xpos, 3'b000} >= XW'(k * H_DISP)) bar = bar + 3'd1;
  end
  assign colour = test_mode ? {{CW{~bar[1]}}, {CW{~bar[2]}}, {CW{~bar[0]}}} : pixel_data;
`else
  logic unused;
  assign unused = test_mode;
  assign colour = pixel_data;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      lcd_hs      <= ~SYNC_POL;
      lcd_vs      <= ~SYNC_POL;
      lcd_de      <= 1'b0;
      lcd_rgb     <= '0;
      lcd_bl      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= !en || h_wrap ? '0 : h_cnt + ONE;
      v_cnt       <= !en ? '0 : h_wrap ? (v_wrap ? '0 : v_cnt + ONE) : v_cnt;
      lcd_hs      <= en && h_cnt < H_S ? SYNC_POL : ~SYNC_POL;
      lcd_vs      <= en && v_cnt < V_S ? SYNC_POL : ~SYNC_POL;
      lcd_de      <= en && data_req;
      lcd_rgb     <= en && data_req ? colour : '0;
      lcd_bl      <= en;
      frame_start <= en && h_cnt == '0 && v_cnt == '0;
    end
  end
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: directed checks of lcd_timing_gen on the 10x6 small configuration
module tb_lcd_timing_gen;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, tm0 = 1'b0, tm1 = 1'b1;
  logic [23:0] pd, rgb, rgb_i;
  logic [3:0]  x, y, x_i, y_i;
  logic        dr, hs, vs, de, bl, fs;
  logic        dr_i, hs_i, vs_i, de_i, bl_i, fs_i;
  int          n = 0, err = 0;

  always #5 clk = ~clk;
  assign pd = 24'hA50000 | {12'h0, y, 4'h0, x};

  lcd_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .V_DISP(3), .V_FRONT(1), .SYNC_POL(1'b0), .COORD_W(4), .RGB_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .test_mode(tm0), .pixel_data(pd), .data_req(dr),
    .pixel_xpos(x), .pixel_ypos(y), .lcd_hs(hs), .lcd_vs(vs), .lcd_de(de), .lcd_rgb(rgb),
    .lcd_bl(bl), .frame_start(fs));

  lcd_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .V_DISP(3), .V_FRONT(1), .SYNC_POL(1'b1), .COORD_W(4), .RGB_W(24)) dut_inv (
    .clk(clk), .rst_n(rst_n), .en(en), .test_mode(tm0), .pixel_data(pd), .data_req(dr_i),
    .pixel_xpos(x_i), .pixel_ypos(y_i), .lcd_hs(hs_i), .lcd_vs(vs_i), .lcd_de(de_i), .lcd_rgb(rgb_i),
    .lcd_bl(bl_i), .frame_start(fs_i));

`ifdef LCD_TEST_PATTERN_EN
  logic [23:0] rgb_t;
  logic [3:0]  x_t, y_t;
  logic        dr_t, hs_t, vs_t, de_t, bl_t, fs_t;
  lcd_timing_gen #(.H_SYNC(2), .H_BACK(2), .H_DISP(8), .H_FRONT(2), .V_SYNC(1), .V_BACK(1),
    .V_DISP(3), .V_FRONT(1), .SYNC_POL(1'b0), .COORD_W(4), .RGB_W(24)) dut_tp (
    .clk(clk), .rst_n(rst_n), .en(en), .test_mode(tm1), .pixel_data(24'h123456), .data_req(dr_t),
    .pixel_xpos(x_t), .pixel_ypos(y_t), .lcd_hs(hs_t), .lcd_vs(vs_t), .lcd_de(de_t), .lcd_rgb(rgb_t),
    .lcd_bl(bl_t), .frame_start(fs_t));
`endif

  typedef struct {
    int          k;
    logic        dr;
    logic [3:0]  x, y;
    logic        de, hs, vs, fs;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " dr"}, {31'b0, dr}, 0);
    chk({tag, " xpos"}, {28'b0, x}, 0);
    chk({tag, " ypos"}, {28'b0, y}, 0);
    chk({tag, " de"}, {31'b0, de}, 0);
    chk({tag, " rgb"}, {8'b0, rgb}, 0);
    chk({tag, " bl"}, {31'b0, bl}, 0);
    chk({tag, " fs"}, {31'b0, fs}, 0);
    chk({tag, " hs"}, {31'b0, hs}, 1);
    chk({tag, " vs"}, {31'b0, vs}, 1);
    chk({tag, " hs_inv"}, {31'b0, hs_i}, 0);
    chk({tag, " vs_inv"}, {31'b0, vs_i}, 0);
  endtask

  initial begin
    int k, hl, vl, hil, fc, dc;
    tbl[0]  = '{1,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};
    tbl[1]  = '{2,  1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[2]  = '{3,  1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 24'h0};
    tbl[3]  = '{11, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0};
    tbl[4]  = '{24, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[5]  = '{25, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA50000};
    tbl[6]  = '{27, 1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA50002};
    tbl[7]  = '{28, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA50003};
    tbl[8]  = '{29, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[9]  = '{47, 1'b1, 4'd3, 4'd2, 1'b1, 1'b1, 1'b1, 1'b0, 24'hA50202};
    tbl[10] = '{54, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
    tbl[11] = '{61, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0};

    do_reset();
    chk_reset("reset");
    k = 0;
    foreach (tbl[i]) begin
      while (k < tbl[i].k) begin
        step();
        k++;
      end
      chk($sformatf("k%0d dr", k), {31'b0, dr}, {31'b0, tbl[i].dr});
      chk($sformatf("k%0d xpos", k), {28'b0, x}, {28'b0, tbl[i].x});
      chk($sformatf("k%0d ypos", k), {28'b0, y}, {28'b0, tbl[i].y});
      chk($sformatf("k%0d de", k), {31'b0, de}, {31'b0, tbl[i].de});
      chk($sformatf("k%0d hs", k), {31'b0, hs}, {31'b0, tbl[i].hs});
      chk($sformatf("k%0d vs", k), {31'b0, vs}, {31'b0, tbl[i].vs});
      chk($sformatf("k%0d fs", k), {31'b0, fs}, {31'b0, tbl[i].fs});
      chk($sformatf("k%0d rgb", k), {8'b0, rgb}, {8'b0, tbl[i].rgb});
      chk($sformatf("k%0d bl", k), {31'b0, bl}, 1);
      chk($sformatf("k%0d hs_inv", k), {31'b0, hs_i}, {31'b0, ~tbl[i].hs});
      chk($sformatf("k%0d vs_inv", k), {31'b0, vs_i}, {31'b0, ~tbl[i].vs});
    end

    hl = 0; vl = 0; hil = 0; fc = 0; dc = 0;
    for (int j = 0; j < 60; j++) begin
      step();
      hl  += int'(!hs);
      vl  += int'(!vs);
      hil += int'(hs_i);
      fc  += int'(fs);
      dc  += int'(de);
    end
    chk("hs low per frame", hl, 12);
    chk("vs low per frame", vl, 10);
    chk("hs_inv high per frame", hil, 12);
    chk("fs per frame", fc, 1);
    chk("de per frame", dc, 12);

    do_reset();
    for (int j = 0; j < 25; j++) step();
    chk("pre-drop dr", {31'b0, dr}, 1);
    en = 1'b0;
    step();
    chk("drop dr", {31'b0, dr}, 0);
    chk("drop de", {31'b0, de}, 0);
    chk("drop rgb", {8'b0, rgb}, 0);
    chk("drop bl", {31'b0, bl}, 0);
    chk("drop hs", {31'b0, hs}, 1);
    chk("drop vs", {31'b0, vs}, 1);
    fc = 0; dc = 0; hl = 0;
    for (int j = 27; j <= 40; j++) begin
      step();
      fc += int'(fs);
      dc += int'(de | dr);
      hl += int'(!hs | !vs);
    end
    chk("idle fs", fc, 0);
    chk("idle de/dr", dc, 0);
    chk("idle sync", hl, 0);
    en = 1'b1;
    step();
    chk("rise fs", {31'b0, fs}, 1);
    chk("rise bl", {31'b0, bl}, 1);
    fc = 0; dc = 0;
    for (int j = 2; j <= 61; j++) begin
      step();
      fc += int'(fs);
      dc += int'(de);
    end
    chk("resume fs at 61", {31'b0, fs}, 1);
    chk("resume fs count", fc, 1);
    chk("resume de count", dc, 12);

    do_reset();
    for (int j = 0; j < 25; j++) step();
    chk("pre-reset de", {31'b0, de}, 1);
    rst_n = 1'b0;
    step();
    chk_reset("midreset");
    rst_n = 1'b1;

`ifdef LCD_TEST_PATTERN_EN
    begin
      logic [23:0] bars[8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      do_reset();
      for (int j = 0; j < 33; j++) step();
      for (int b = 0; b < 8; b++) begin
        chk($sformatf("bar%0d de", b), {31'b0, de_t}, 1);
        chk($sformatf("bar%0d rgb", b), {8'b0, rgb_t}, {8'b0, bars[b]});
        step();
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", err, n);
    $finish;
  end
endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB-LCD timing generator: the next-generation replacement for the fixed 800x480 driver behind the display top. All sync, porch and active widths are set by parameters, so one block serves every panel we carry. It issues a pixel request with coordinates one cycle ahead of the active window, registers the returned colour, and drives sync, data-enable, backlight and a frame-start strobe. An optional built-in colour-bar generator is available for panel bring-up.

## Interface
- H_SYNC, 128, hsync width in pixel clocks
- H_BACK, 88, horizontal back porch
- H_DISP, 800, active pixels per line
- H_FRONT, 40, horizontal front porch
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines
- V_FRONT, 10, vertical front porch
- SYNC_POL, 0, sync active level (0 = active-low)
- COORD_W, 11, counter and coordinate width; H_TOTAL-1 and V_TOTAL-1 must fit
- RGB_W, 24, colour width, a multiple of 3
- clk  in  1  pixel clock; all logic on the rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  timing run enable
- test_mode  in  1  selects colour bars (functional only with LCD_TEST_PATTERN_EN)
- pixel_data  in  RGB_W  colour for the requested coordinate, sampled while data_req=1
- data_req  out  1  pixel request; coordinates valid
- pixel_xpos  out  COORD_W  requested x, 0..H_DISP-1, 0 when data_req=0
- pixel_ypos  out  COORD_W  requested y, 0..V_DISP-1, 0 when data_req=0
- lcd_hs  out  1  horizontal sync
- lcd_vs  out  1  vertical sync
- lcd_de  out  1  data enable
- lcd_rgb  out  RGB_W  pixel colour; 0 when lcd_de=0
- lcd_bl  out  1  backlight enable
- frame_start  out  1  one-cycle strobe at the start of each frame

## Operation
- H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL is the sum of the four V_* parameters.
- h_cnt counts 0..H_TOTAL-1 and wraps. v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1.
- Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP) and v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP).
- data_req is a decode of the counter registers: high when the counters are in the active window.
  - pixel_xpos = h_cnt-(H_SYNC+H_BACK); pixel_ypos = v_cnt-(V_SYNC+V_BACK).
- Registered one cycle after the counter state:
  - lcd_de is data_req delayed by one cycle.
  - lcd_hs = SYNC_POL when h_cnt<H_SYNC, else ~SYNC_POL. lcd_vs uses the same rule on v_cnt<V_SYNC.
  - lcd_rgb = pixel_data (or the test pattern) when data_req=1, else 0.
  - frame_start = 1 when h_cnt==0 and v_cnt==0.
- lcd_bl is en registered.
- en=0: at the next edge the counters clear to 0 and are held there.
  - data_req, lcd_de, frame_start and lcd_rgb are held at 0; syncs are held inactive.
  - When en rises, counting resumes from 0,0, so the first frame is complete.
- The counters use no arithmetic wrap beyond the explicit terminal-count compare. Coordinate subtraction is performed only inside the active window.

## Timing
- Reset values:
  - Counters = 0.
  - lcd_hs = lcd_vs = ~SYNC_POL.
  - lcd_de, lcd_rgb, lcd_bl, frame_start, data_req, pixel_xpos and pixel_ypos = 0.
- Latency: data_req to lcd_de/lcd_rgb is exactly 1 cycle. The upstream source must produce pixel_data combinationally from pixel_xpos/pixel_ypos within the same cycle.
- Sync, de and rgb all leave the same register stage and are therefore mutually aligned.
- The last active pixel is followed directly by the front porch. data_req never spans a line boundary.
- An rst_n or en drop mid-line aborts the line immediately; no partial-frame state is kept.
- Frame period = H_TOTAL*V_TOTAL cycles: 554400 at the default parameters.

## Configuration
- LCD_TEST_PATTERN_EN defined: when test_mode=1, lcd_rgb is replaced by eight vertical colour bars.
  - Bar index = pixel_xpos*8/H_DISP, computed via a compare chain with no divider.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - pixel_data is ignored in this mode, but data_req is still issued.
- LCD_TEST_PATTERN_EN undefined: the test_mode port exists but is ignored, and no pattern logic is synthesised.

## Test plan
Benches use the small configuration H=2/2/4/2 (H_TOTAL=10) and V=1/1/3/1 (V_TOTAL=6).
- Reset and run with en=1:
  - data_req is high for h_cnt 4..7 on lines 2..4, with xpos 0..3 and ypos 0..2.
  - lcd_de follows one cycle later.
  - frame_start pulses every 60 cycles.
- Drive pixel_data = {ypos,xpos}-derived value -> lcd_rgb equals that value one cycle later during lcd_de, and is 0 elsewhere.
- Sync check:
  - lcd_hs is low for exactly 2 cycles per 10; lcd_vs is low for exactly 10 cycles per 60.
  - With SYNC_POL=1, both are inverted.
- en drops at cycle 25 (mid-line 2), then rises at 40:
  - Outputs go idle and lcd_bl goes to 0 one cycle after the drop.
  - frame_start occurs one cycle after en rises, and a full frame follows.
- rst_n asserted mid-active-pixel -> all outputs take their reset values at the next edge.
- LCD_TEST_PATTERN_EN defined, test_mode=1, H_DISP=8 -> lcd_rgb sequence across a line: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
